led_seq_ctrl: RTL

//  Sequencer for the 4-bit board LED bank. Accepts a command (mode, step count)

---
 rtl/led_seq_pkg.sv | 14 +
 rtl/led_tick_gen.sv | 18 +
 rtl/led_seq_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: modes, FSM states and start patterns shared by the LED sequencer.
// Start patterns are 32 bits wide and get truncated to the LED bank width.
package led_seq_pkg;
    typedef enum logic [1:0] {MODE_OFF, MODE_LIGHT, MODE_BLINK, MODE_COUNT} mode_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    localparam logic [31:0] PAT_OFF   = '0;
    localparam logic [31:0] PAT_LIGHT = 32'd1;
    localparam logic [31:0] PAT_BLINK = '1;
    localparam logic [31:0] PAT_COUNT = 32'd1;
    function automatic logic [31:0] start_pat(input mode_t m);
        return m == MODE_LIGHT ? PAT_LIGHT : m == MODE_BLINK ? PAT_BLINK :
               m == MODE_COUNT ? PAT_COUNT : PAT_OFF;
    endfunction
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: step prescaler, pulses tick on the last of every STEP_CYCLES enabled clocks.
module led_tick_gen #(
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(STEP_CYCLES);
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(STEP_CYCLES - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: command-driven LED pattern sequencer stepping once per STEP_CYCLES clocks.
// Define LED_SEQ_PWM_EN to add a brightness input with 16-level PWM dimming.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 25_000_000,
    parameter int LED_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [7:0]       cmd_steps,
    input  logic             stop,
`ifdef LED_SEQ_PWM_EN
    input  logic [3:0]       brightness,
`endif
    output logic             busy,
    output logic             done,
    output logic [LED_W-1:0] led
);
    state_t           state;
    mode_t            mode;
    logic [7:0]       remain;
    logic [LED_W-1:0] pattern, next_pat;
    logic             tick, accept;
    assign cmd_ready = state == ST_IDLE && !stop;
    assign accept    = cmd_valid && cmd_ready;
    assign next_pat  = mode == MODE_LIGHT ? {pattern[LED_W-2:0], pattern[LED_W-1]} :
                       mode == MODE_BLINK ? ~pattern :
                       mode == MODE_COUNT ? pattern + LED_W'(1) : '0;
    led_tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (state == ST_RUN),
        .clr (accept),
        .tick(tick)
    );
    // remain==0 means run until stop; a finite count leaves RUN on the tick where remain==1
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= ST_IDLE;
            mode    <= MODE_OFF;
            remain  <= '0;
            pattern <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE:
                    if (stop) pattern <= '0;
                    else if (cmd_valid) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        mode    <= mode_t'(cmd_mode);
                        remain  <= cmd_steps;
                        pattern <= LED_W'(start_pat(mode_t'(cmd_mode)));
                    end
                ST_RUN:
                    if (stop) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        pattern <= '0;
                    end else if (tick) begin
                        pattern <= next_pat;
                        if (remain == 8'd1) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (remain != 8'd0) remain <= remain - 8'd1;
                    end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    if (stop) pattern <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
`ifdef LED_SEQ_PWM_EN
    logic [3:0] pwm_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) pwm_cnt <= '0;
        else pwm_cnt <= pwm_cnt + 4'd1;
    assign led = pattern & {LED_W{pwm_cnt < brightness}};
`else
    assign led = pattern;
`endif
endmodule
